// File: rtl/video_stream_checker_pkg.sv
// rtl/video_stream_checker_pkg.sv - register map, FSM states and helpers for video_stream_checker
package video_stream_checker_pkg;

   localparam logic [2:0] REG_CORE_ID     = 3'd0;
   localparam logic [2:0] REG_CTL         = 3'd1;
   localparam logic [2:0] REG_EXP_WIDTH   = 3'd2;
   localparam logic [2:0] REG_EXP_HEIGHT  = 3'd3;
   localparam logic [2:0] REG_STATUS      = 3'd4;
   localparam logic [2:0] REG_FRAME_COUNT = 3'd5;
   localparam logic [2:0] REG_ERR_COUNT   = 3'd6;
   localparam logic [2:0] REG_CHECKSUM    = 3'd7;

   localparam int CTL_ENABLE_BIT      = 0;
   localparam int STATUS_IN_FRAME_BIT = 0;
   localparam int STATUS_LAST_OK_BIT  = 1;

   typedef enum logic {IDLE, FRAME} state_t;

   function automatic logic [63:0] strb_merge(input logic [63:0] old_value,
                                              input logic [63:0] new_value,
                                              input logic [7:0]  strb);
      logic [63:0] res;
      for (int i = 0; i < 8; i++) begin
         res[i*8 +: 8] = strb[i] ? new_value[i*8 +: 8] : old_value[i*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/video_stream_checker_if.sv
// rtl/video_stream_checker_if.sv - AXI4-Lite register bus plus AXI4-Stream video sink signals
interface video_stream_checker_if #(parameter int DATA_BITS = 10);

   logic [39:0]          s_axi4l_awaddr;
   logic [2:0]           s_axi4l_awprot;
   logic                 s_axi4l_awvalid;
   logic                 s_axi4l_awready;
   logic [63:0]          s_axi4l_wdata;
   logic [7:0]           s_axi4l_wstrb;
   logic                 s_axi4l_wvalid;
   logic                 s_axi4l_wready;
   logic [1:0]           s_axi4l_bresp;
   logic                 s_axi4l_bvalid;
   logic                 s_axi4l_bready;
   logic [39:0]          s_axi4l_araddr;
   logic [2:0]           s_axi4l_arprot;
   logic                 s_axi4l_arvalid;
   logic                 s_axi4l_arready;
   logic [63:0]          s_axi4l_rdata;
   logic [1:0]           s_axi4l_rresp;
   logic                 s_axi4l_rvalid;
   logic                 s_axi4l_rready;
   logic                 s_axi4s_tuser;
   logic                 s_axi4s_tlast;
   logic [DATA_BITS-1:0] s_axi4s_tdata;
   logic                 s_axi4s_tvalid;
   logic                 s_axi4s_tready;

   modport master (
      output s_axi4l_awaddr, s_axi4l_awprot, s_axi4l_awvalid,
      input  s_axi4l_awready,
      output s_axi4l_wdata, s_axi4l_wstrb, s_axi4l_wvalid,
      input  s_axi4l_wready,
      input  s_axi4l_bresp, s_axi4l_bvalid,
      output s_axi4l_bready,
      output s_axi4l_araddr, s_axi4l_arprot, s_axi4l_arvalid,
      input  s_axi4l_arready,
      input  s_axi4l_rdata, s_axi4l_rresp, s_axi4l_rvalid,
      output s_axi4l_rready,
      output s_axi4s_tuser, s_axi4s_tlast, s_axi4s_tdata, s_axi4s_tvalid,
      input  s_axi4s_tready
   );

   modport slave (
      input  s_axi4l_awaddr, s_axi4l_awprot, s_axi4l_awvalid,
      output s_axi4l_awready,
      input  s_axi4l_wdata, s_axi4l_wstrb, s_axi4l_wvalid,
      output s_axi4l_wready,
      output s_axi4l_bresp, s_axi4l_bvalid,
      input  s_axi4l_bready,
      input  s_axi4l_araddr, s_axi4l_arprot, s_axi4l_arvalid,
      output s_axi4l_arready,
      output s_axi4l_rdata, s_axi4l_rresp, s_axi4l_rvalid,
      input  s_axi4l_rready,
      input  s_axi4s_tuser, s_axi4s_tlast, s_axi4s_tdata, s_axi4s_tvalid,
      output s_axi4s_tready
   );

endinterface

// File: rtl/video_stream_checker_axi4l_regs.sv
// rtl/video_stream_checker_axi4l_regs.sv - AXI4-Lite responder and control/status register file
module video_stream_checker_axi4l_regs
   import video_stream_checker_pkg::*;
#(
   parameter int          X_BITS      = 16,
   parameter int          Y_BITS      = 16,
   parameter logic [63:0] CORE_ID     = 64'h0000_0000_5643_0001,
   parameter logic        INIT_ENABLE = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   video_stream_checker_if.slave bus,
   input  logic                in_frame,
   input  logic                last_frame_ok,
   input  logic [31:0]         frame_count,
   input  logic [31:0]         err_count,
   input  logic [31:0]         checksum,
   output logic                enable,
   output logic [X_BITS-1:0]   exp_width,
   output logic [Y_BITS-1:0]   exp_height,
   output logic                wr_pulse,
   output logic [2:0]          wr_idx,
   output logic [63:0]         wr_data
);

   logic        awready_q, bvalid_q, arready_q, rvalid_q;
   logic [63:0] rdata_q;
   logic [63:0] wr_old, wr_merged, rd_value;
   logic [2:0]  rd_idx;

   // Address and data are taken together; the register updates on the ready cycle.
   assign wr_pulse = awready_q && bus.s_axi4l_awvalid && bus.s_axi4l_wvalid;
   assign wr_idx   = bus.s_axi4l_awaddr[5:3];
   assign wr_data  = bus.s_axi4l_wdata;
   assign rd_idx   = bus.s_axi4l_araddr[5:3];

   always_comb begin
      wr_old = '0;
      case (wr_idx)
         REG_CTL:        wr_old[CTL_ENABLE_BIT] = enable;
         REG_EXP_WIDTH:  wr_old = 64'(exp_width);
         REG_EXP_HEIGHT: wr_old = 64'(exp_height);
         default:        wr_old = '0;
      endcase
      wr_merged = strb_merge(wr_old, bus.s_axi4l_wdata, bus.s_axi4l_wstrb);
   end

   always_comb begin
      rd_value = '0;
      case (rd_idx)
         REG_CORE_ID:     rd_value = CORE_ID;
         REG_CTL:         rd_value[CTL_ENABLE_BIT] = enable;
         REG_EXP_WIDTH:   rd_value = 64'(exp_width);
         REG_EXP_HEIGHT:  rd_value = 64'(exp_height);
         REG_STATUS: begin
            rd_value[STATUS_IN_FRAME_BIT] = in_frame;
            rd_value[STATUS_LAST_OK_BIT]  = last_frame_ok;
         end
         REG_FRAME_COUNT: rd_value = 64'(frame_count);
         REG_ERR_COUNT:   rd_value = 64'(err_count);
         REG_CHECKSUM:    rd_value = 64'(checksum);
         default:         rd_value = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         awready_q  <= 1'b0;
         bvalid_q   <= 1'b0;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         enable     <= INIT_ENABLE;
         exp_width  <= '0;
         exp_height <= '0;
      end else begin
         awready_q <= bus.s_axi4l_awvalid && bus.s_axi4l_wvalid && !bvalid_q && !awready_q;
         if (wr_pulse) begin
            bvalid_q <= 1'b1;
         end else if (bvalid_q && bus.s_axi4l_bready) begin
            bvalid_q <= 1'b0;
         end

         arready_q <= bus.s_axi4l_arvalid && !rvalid_q && !arready_q;
         if (arready_q && bus.s_axi4l_arvalid) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_value;
         end else if (rvalid_q && bus.s_axi4l_rready) begin
            rvalid_q <= 1'b0;
         end

         if (wr_pulse) begin
            case (wr_idx)
               REG_CTL:        enable     <= wr_merged[CTL_ENABLE_BIT];
               REG_EXP_WIDTH:  exp_width  <= wr_merged[X_BITS-1:0];
               REG_EXP_HEIGHT: exp_height <= wr_merged[Y_BITS-1:0];
               default:        ;
            endcase
         end
      end
   end

   assign bus.s_axi4l_awready = awready_q;
   assign bus.s_axi4l_wready  = awready_q;
   assign bus.s_axi4l_bresp   = 2'b00;
   assign bus.s_axi4l_bvalid  = bvalid_q;
   assign bus.s_axi4l_arready = arready_q;
   assign bus.s_axi4l_rdata   = rdata_q;
   assign bus.s_axi4l_rresp   = 2'b00;
   assign bus.s_axi4l_rvalid  = rvalid_q;

   logic unused_bits;
   assign unused_bits = ^{bus.s_axi4l_awprot, bus.s_axi4l_arprot,
                          bus.s_axi4l_awaddr[39:6], bus.s_axi4l_awaddr[2:0],
                          bus.s_axi4l_araddr[39:6], bus.s_axi4l_araddr[2:0], wr_merged};

endmodule

// File: rtl/video_stream_checker.sv
// rtl/video_stream_checker.sv - AXI4-Stream video sink checking frame geometry, counting frames/errors
// Optional per-frame tdata sum in register 7 when VIDEO_STREAM_CHECKER_CHECKSUM_EN is defined.
module video_stream_checker
   import video_stream_checker_pkg::*;
#(
   parameter int          DATA_BITS   = 10,
   parameter int          X_BITS      = 16,
   parameter int          Y_BITS      = 16,
   parameter logic [63:0] CORE_ID     = 64'h0000_0000_5643_0001,
   parameter logic        INIT_ENABLE = 1'b0
) (
   input logic aclk,
   input logic aresetn,
   video_stream_checker_if.slave bus
);

   state_t            state, state_n;
   logic [X_BITS-1:0] x, x_n, col, w_last, exp_width;
   logic [Y_BITS-1:0] y, y_n, row, h_last, exp_height;
   logic              frame_err, frame_err_n, err_base;
   logic              last_ok, last_ok_n;
   logic [31:0]       frame_count, frame_count_n, err_count, err_count_n, checksum;
   logic              enable, acc, active, at_last, line_end, line_bad, frame_done, beat_err, err_clr;
   logic              wr_pulse;
   logic [2:0]        wr_idx;
   logic [63:0]       wr_data;

   // Programmed sizes of 0 and 1 both mean a single column/row.
   assign w_last  = (exp_width  <= X_BITS'(1)) ? '0 : exp_width  - X_BITS'(1);
   assign h_last  = (exp_height <= Y_BITS'(1)) ? '0 : exp_height - Y_BITS'(1);
   assign acc     = bus.s_axi4s_tvalid && enable;
   assign err_clr = wr_pulse && (wr_idx == REG_ERR_COUNT);
   assign bus.s_axi4s_tready = enable;

   always_comb begin
      state_n       = state;
      x_n           = x;
      y_n           = y;
      frame_err_n   = frame_err;
      frame_count_n = frame_count;
      last_ok_n     = last_ok;
      col           = x;
      row           = y;
      err_base      = frame_err;
      beat_err      = 1'b0;
      at_last       = 1'b0;
      line_end      = 1'b0;
      line_bad      = 1'b0;
      frame_done    = 1'b0;
      active        = acc && (bus.s_axi4s_tuser || state == FRAME);

      // A start-of-frame beat is column 0 of a fresh frame; inside a frame it also abandons the old one.
      if (acc && bus.s_axi4s_tuser) begin
         col      = '0;
         row      = '0;
         err_base = 1'b0;
         beat_err = (state == FRAME);
      end

      if (active) begin
         at_last     = (col == w_last);
         line_end    = bus.s_axi4s_tlast || at_last;
         line_bad    = bus.s_axi4s_tlast != at_last;
         beat_err    = beat_err || line_bad;
         state_n     = FRAME;
         x_n         = col + X_BITS'(1);
         y_n         = row;
         frame_err_n = err_base || line_bad;
         if (line_end) begin
            x_n = '0;
            y_n = row + Y_BITS'(1);
            if (row == h_last) begin
               frame_done    = 1'b1;
               state_n       = IDLE;
               y_n           = '0;
               frame_err_n   = 1'b0;
               frame_count_n = frame_count + 32'd1;
               last_ok_n     = !(err_base || line_bad);
            end
         end
      end
   end

   // A clear in the same cycle as an error wins.
   assign err_count_n = err_clr ? 32'd0 :
                        (beat_err && err_count != 32'hFFFF_FFFF) ? err_count + 32'd1 : err_count;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state       <= IDLE;
         x           <= '0;
         y           <= '0;
         frame_err   <= 1'b0;
         last_ok     <= 1'b0;
         frame_count <= '0;
         err_count   <= '0;
      end else begin
         state       <= state_n;
         x           <= x_n;
         y           <= y_n;
         frame_err   <= frame_err_n;
         last_ok     <= last_ok_n;
         frame_count <= frame_count_n;
         err_count   <= err_count_n;
      end
   end

`ifdef VIDEO_STREAM_CHECKER_CHECKSUM_EN
   logic [31:0] sum, sum_n, checksum_n;

   always_comb begin
      sum_n      = sum;
      checksum_n = checksum;
      if (active) begin
         sum_n = ((acc && bus.s_axi4s_tuser) ? 32'd0 : sum) + 32'(bus.s_axi4s_tdata);
         if (frame_done) begin
            checksum_n = sum_n;
            sum_n      = '0;
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         sum      <= '0;
         checksum <= '0;
      end else begin
         sum      <= sum_n;
         checksum <= checksum_n;
      end
   end
`else
   assign checksum = '0;

   logic unused_data;
   assign unused_data = ^{bus.s_axi4s_tdata, frame_done};
`endif

   logic unused_wr;
   assign unused_wr = ^wr_data;

   video_stream_checker_axi4l_regs #(
      .X_BITS      (X_BITS),
      .Y_BITS      (Y_BITS),
      .CORE_ID     (CORE_ID),
      .INIT_ENABLE (INIT_ENABLE)
   ) u_regs (
      .clk           (aclk),
      .rst_n         (aresetn),
      .bus           (bus),
      .in_frame      (state == FRAME),
      .last_frame_ok (last_ok),
      .frame_count   (frame_count),
      .err_count     (err_count),
      .checksum      (checksum),
      .enable        (enable),
      .exp_width     (exp_width),
      .exp_height    (exp_height),
      .wr_pulse      (wr_pulse),
      .wr_idx        (wr_idx),
      .wr_data       (wr_data)
   );

endmodule

// File: tb/tb_video_stream_checker.sv
// tb/tb_video_stream_checker.sv - directed self-checking bench for video_stream_checker
module tb_video_stream_checker;

   localparam logic [63:0] CORE_ID = 64'h0000_0000_5643_0001;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   int   checks = 0;
   int   fails = 0;
   logic [63:0] rd;
   logic [63:0] exp_cksum;
   logic [1:0]  last_rresp;

   always #5 aclk = ~aclk;

   video_stream_checker_if #(.DATA_BITS(10)) bus ();

   video_stream_checker #(
      .DATA_BITS   (10),
      .X_BITS      (16),
      .Y_BITS      (16),
      .CORE_ID     (CORE_ID),
      .INIT_ENABLE (1'b0)
   ) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .bus     (bus)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic axi_write(input int idx, input logic [63:0] data, input logic [7:0] strb);
      int n;
      @(negedge aclk);
      bus.s_axi4l_awaddr  = 40'(idx) << 3;
      bus.s_axi4l_awvalid = 1'b1;
      bus.s_axi4l_wdata   = data;
      bus.s_axi4l_wstrb   = strb;
      bus.s_axi4l_wvalid  = 1'b1;
      n = 0;
      do begin
         @(negedge aclk);
         n++;
      end while (!bus.s_axi4l_awready && n < 20);
      check("aw_ready", 64'(bus.s_axi4l_awready), 64'd1);
      @(negedge aclk);
      bus.s_axi4l_awvalid = 1'b0;
      bus.s_axi4l_wvalid  = 1'b0;
      bus.s_axi4l_bready  = 1'b1;
      n = 0;
      while (!bus.s_axi4l_bvalid && n < 20) begin
         @(negedge aclk);
         n++;
      end
      check("b_valid", 64'(bus.s_axi4l_bvalid), 64'd1);
      @(negedge aclk);
      bus.s_axi4l_bready = 1'b0;
   endtask

   task automatic axi_read(input int idx, output logic [63:0] data);
      int n;
      @(negedge aclk);
      bus.s_axi4l_araddr  = 40'(idx) << 3;
      bus.s_axi4l_arvalid = 1'b1;
      n = 0;
      do begin
         @(negedge aclk);
         n++;
      end while (!bus.s_axi4l_arready && n < 20);
      @(negedge aclk);
      bus.s_axi4l_arvalid = 1'b0;
      bus.s_axi4l_rready  = 1'b1;
      n = 0;
      while (!bus.s_axi4l_rvalid && n < 20) begin
         @(negedge aclk);
         n++;
      end
      data       = bus.s_axi4l_rvalid ? bus.s_axi4l_rdata : 64'hDEAD_DEAD_DEAD_DEAD;
      last_rresp = bus.s_axi4l_rresp;
      @(negedge aclk);
      bus.s_axi4l_rready = 1'b0;
   endtask

   task automatic read_check(input string tag, input int idx, input logic [63:0] exp);
      logic [63:0] v;
      axi_read(idx, v);
      check(tag, v, exp);
   endtask

   task automatic beat(input bit user, input bit last, input int data);
      @(negedge aclk);
      bus.s_axi4s_tvalid = 1'b1;
      bus.s_axi4s_tuser  = user;
      bus.s_axi4s_tlast  = last;
      bus.s_axi4s_tdata  = 10'(data);
      @(negedge aclk);
      bus.s_axi4s_tvalid = 1'b0;
      bus.s_axi4s_tuser  = 1'b0;
      bus.s_axi4s_tlast  = 1'b0;
   endtask

   task automatic send_line(input int w, input bit sof);
      for (int c = 0; c < w; c++) beat(sof && c == 0, c == w - 1, c);
   endtask

   initial begin
      bus.s_axi4l_awaddr = '0; bus.s_axi4l_awprot = '0; bus.s_axi4l_awvalid = 1'b0;
      bus.s_axi4l_wdata = '0; bus.s_axi4l_wstrb = '0; bus.s_axi4l_wvalid = 1'b0;
      bus.s_axi4l_bready = 1'b0; bus.s_axi4l_araddr = '0; bus.s_axi4l_arprot = '0;
      bus.s_axi4l_arvalid = 1'b0; bus.s_axi4l_rready = 1'b0;
      bus.s_axi4s_tuser = 1'b0; bus.s_axi4s_tlast = 1'b0; bus.s_axi4s_tdata = '0;
      bus.s_axi4s_tvalid = 1'b0;
      repeat (3) @(negedge aclk);
      aresetn = 1'b1;

      // Reset state
      check("reset_tready", 64'(bus.s_axi4s_tready), 64'd0);
      check("reset_bvalid", 64'(bus.s_axi4l_bvalid), 64'd0);
      read_check("reset_core_id", 0, CORE_ID);
      check("rresp", 64'(last_rresp), 64'd0);
      read_check("reset_frame_count", 5, 64'd0);
      read_check("reset_err_count", 6, 64'd0);
      read_check("reset_exp_width", 2, 64'd0);
      read_check("reset_status", 4, 64'd0);

      // Clean 4x3 frame
      axi_write(2, 64'd4, 8'hFF);
      axi_write(3, 64'd3, 8'hFF);
      axi_write(1, 64'd1, 8'hFF);
      check("enabled_tready", 64'(bus.s_axi4s_tready), 64'd1);
      send_line(4, 1'b1); send_line(4, 1'b0); send_line(4, 1'b0);
      read_check("clean_frame_count", 5, 64'd1);
      read_check("clean_err_count", 6, 64'd0);
      read_check("clean_status", 4, 64'd2);

      // Line 1 ends early at x=2
      send_line(4, 1'b1);
      beat(0, 0, 0); beat(0, 0, 1); beat(0, 1, 2);
      send_line(4, 1'b0);
      read_check("short_line_frame_count", 5, 64'd2);
      read_check("short_line_err_count", 6, 64'd1);
      read_check("short_line_status", 4, 64'd0);

      // Any write clears ERR_COUNT
      axi_write(6, 64'h55, 8'hFF);
      read_check("err_cleared", 6, 64'd0);

      // tuser at x=1,y=1 restarts; the restarted frame completes cleanly
      send_line(4, 1'b1);
      beat(0, 0, 0);
      beat(1, 0, 0);
      beat(0, 0, 1); beat(0, 0, 2); beat(0, 1, 3);
      send_line(4, 1'b0); send_line(4, 1'b0);
      read_check("restart_err_count", 6, 64'd1);
      read_check("restart_frame_count", 5, 64'd3);
      read_check("restart_status", 4, 64'd2);

      // Build ERR_COUNT to 5 with repeated tuser inside a frame
      beat(1, 0, 0);
      repeat (4) beat(1, 0, 0);
      read_check("err_count_five", 6, 64'd5);
      read_check("in_frame_status", 4, 64'd3);

      // Clear write lands on the same edge as an error beat
      @(negedge aclk);
      bus.s_axi4l_awaddr = 40'(6) << 3; bus.s_axi4l_wdata = '0; bus.s_axi4l_wstrb = 8'hFF;
      bus.s_axi4l_awvalid = 1'b1; bus.s_axi4l_wvalid = 1'b1;
      @(negedge aclk);
      check("sim_aw_ready", 64'(bus.s_axi4l_awready), 64'd1);
      bus.s_axi4s_tvalid = 1'b1; bus.s_axi4s_tuser = 1'b1;
      @(negedge aclk);
      bus.s_axi4l_awvalid = 1'b0; bus.s_axi4l_wvalid = 1'b0;
      bus.s_axi4s_tvalid = 1'b0; bus.s_axi4s_tuser = 1'b0;
      check("sim_bvalid", 64'(bus.s_axi4l_bvalid), 64'd1);
      bus.s_axi4l_bready = 1'b1;
      @(negedge aclk);
      bus.s_axi4l_bready = 1'b0;
      read_check("clear_wins", 6, 64'd0);

      // Disable mid-frame, then resume the same frame
      axi_write(1, 64'd0, 8'hFF);
      check("disabled_tready", 64'(bus.s_axi4s_tready), 64'd0);
      beat(0, 0, 7);
      read_check("disabled_status", 4, 64'd3);
      axi_write(1, 64'd1, 8'hFF);
      beat(0, 0, 1); beat(0, 0, 2); beat(0, 1, 3);
      send_line(4, 1'b0); send_line(4, 1'b0);
      read_check("resume_frame_count", 5, 64'd4);
      read_check("resume_err_count", 6, 64'd0);
      read_check("resume_status", 4, 64'd2);

      // Byte strobes and read-only core id
      axi_write(2, 64'h1234_5678_9ABC_DEF0, 8'h01);
      read_check("strobe_width", 2, 64'hF0);
      axi_write(0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
      read_check("core_id_ro", 0, CORE_ID);
      read_check("ctl_readback", 1, 64'd1);

      // Width 0 behaves as width 1: a single tuser+tlast beat is a whole frame
      axi_write(2, 64'd0, 8'hFF);
      axi_write(3, 64'd1, 8'hFF);
      beat(1, 1, 9);
      read_check("w0_frame_count", 5, 64'd5);
      read_check("w0_status", 4, 64'd2);
      read_check("w0_err_count", 6, 64'd0);

      // 2x2 frame with data 1,2,3,4
      axi_write(2, 64'd2, 8'hFF);
      axi_write(3, 64'd2, 8'hFF);
      beat(1, 0, 1); beat(0, 1, 2); beat(0, 0, 3); beat(0, 1, 4);
`ifdef VIDEO_STREAM_CHECKER_CHECKSUM_EN
      exp_cksum = 64'd10;
`else
      exp_cksum = 64'd0;
`endif
      read_check("checksum", 7, exp_cksum);
      read_check("cksum_frame_count", 5, 64'd6);

      // Asynchronous reset mid-frame
      beat(1, 0, 0);
      @(negedge aclk);
      #2 aresetn = 1'b0;
      #1 check("async_reset_tready", 64'(bus.s_axi4s_tready), 64'd0);
      @(negedge aclk);
      aresetn = 1'b1;
      read_check("after_reset_frame_count", 5, 64'd0);
      read_check("after_reset_width", 2, 64'd0);
      read_check("after_reset_status", 4, 64'd0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/video_stream_checker.md
Name: video_stream_checker

Overview:
- Synthesizable AXI4-Stream video sink that consumes the camera/processing pixel stream (tuser = start of frame, tlast = end of line).
- Checks each frame's geometry against programmed width and height, and counts good frames and framing errors.
- Registers are exposed on an AXI4-Lite responder hung off the peripheral bus.
- Used on-board as a stream terminator and by the bench for frame-integrity checking.

Parameters:
- DATA_BITS, 10, pixel width of s_axi4s_tdata
- X_BITS, 16, width of column counter and EXP_WIDTH
- Y_BITS, 16, width of row counter and EXP_HEIGHT
- CORE_ID, 64'h0000_0000_5643_0001, value of register 0
- INIT_ENABLE, 1'b0, reset value of CTL.enable

Ports:
- aclk  in  1  single clock for stream and register bus
- aresetn  in  1  asynchronous active-low reset
- s_axi4l_awaddr  in  40  write address; register index = awaddr[5:3]
- s_axi4l_awprot  in  3  ignored
- s_axi4l_awvalid/awready  in/out  1  write address handshake
- s_axi4l_wdata  in  64  write data
- s_axi4l_wstrb  in  8  byte strobes
- s_axi4l_wvalid/wready  in/out  1  write data handshake
- s_axi4l_bresp  out  2  always 2'b00
- s_axi4l_bvalid/bready  out/in  1  write response
- s_axi4l_araddr  in  40  read address; index = araddr[5:3]
- s_axi4l_arprot  in  3  ignored
- s_axi4l_arvalid/arready  in/out  1  read address handshake
- s_axi4l_rdata  out  64  read data
- s_axi4l_rresp  out  2  always 2'b00
- s_axi4l_rvalid/rready  out/in  1  read data handshake
- s_axi4s_tuser  in  1  start of frame
- s_axi4s_tlast  in  1  end of line
- s_axi4s_tdata  in  DATA_BITS  pixel
- s_axi4s_tvalid/tready  in/out  1  stream handshake; tready = CTL.enable

Behaviour:
- Reset values: all AXI4-Lite ready/valid outputs 0, rdata 0, tready = INIT_ENABLE, EXP_WIDTH = 0, EXP_HEIGHT = 0, counters 0, state IDLE.
- Register map (64-bit, write strobes honoured per byte):
  - 0 CORE_ID (RO)
  - 1 CTL: bit0 enable (RW)
  - 2 EXP_WIDTH (RW)
  - 3 EXP_HEIGHT (RW)
  - 4 STATUS (RO): bit0 in_frame, bit1 last_frame_ok
  - 5 FRAME_COUNT (RO, 32b, wraps)
  - 6 ERR_COUNT (RO, 32b, saturates at 0xFFFF_FFFF; any write clears it)
  - 7 CHECKSUM (RO)
  - Unmapped addresses read 0.
- Write channel:
  - awready and wready assert together for one cycle when awvalid && wvalid && !bvalid.
  - Register update happens on that cycle; bvalid rises the next cycle and holds until bready.
- Read channel:
  - arready is asserted for one cycle when arvalid && !rvalid.
  - rdata is latched; rvalid rises the next cycle and holds until rready.
- One outstanding transaction per channel. Read and write channels are independent.
- Stream beat: acc = tvalid && tready. No internal latency; all checks evaluate on the accepting beat.
- FSM IDLE: beats without tuser are discarded, and no error is counted. A beat with tuser sets x=1, y=0 and moves to FRAME. If that beat also has tlast, the line-end rule is applied immediately.
- FSM FRAME: every acc increments x.
  - tlast with x == EXP_WIDTH-1 is a good line end: x=0, y++.
  - tlast at any other x is an error: err++, and the line ends anyway (x=0, y++).
  - x reaching EXP_WIDTH-1 without tlast is an error: err++, x=0, y++ (resync on counter).
  - When the line ending has y == EXP_HEIGHT-1: FRAME_COUNT++, last_frame_ok = (no error in this frame), return to IDLE.
  - tuser in FRAME is an error: err++, the current frame is abandoned with no FRAME_COUNT increment, and a new frame starts from this beat (x=1, y=0).
- Simultaneous events: an ERR_COUNT write and an error increment in the same cycle yield 0 (clear wins). A CTL write disabling mid-frame drops tready next cycle; FSM state is retained and resumes when re-enabled.
- EXP_WIDTH or EXP_HEIGHT of 0 or 1 is treated as 1. Writing these registers mid-frame takes effect immediately.
- Reset assertion mid-frame or mid-transaction returns everything to reset values asynchronously.

Optional Feature:
- Macro VIDEO_STREAM_CHECKER_CHECKSUM_EN.
- Defined: CHECKSUM accumulates a 32-bit wrapping sum of tdata over accepted beats of the current frame, latched to register 7 at frame completion.
- Undefined: register 7 reads 0 and no accumulator is built.

Decomposition:
- Package video_stream_checker_pkg holds:
  - register index localparams REG_CORE_ID..REG_CHECKSUM
  - state enum state_t {IDLE, FRAME}
  - CTL bit position constants
- One sub-module, video_stream_checker_axi4l_regs: AXI4-Lite handshake plus register file, exposing write pulse, index and data to the checker core.

Test Plan:
- Reset with INIT_ENABLE=0 → tready=0; reads return reg0 = 0x0000_0000_5643_0001, reg5 = 0, reg6 = 0.
- Write EXP_WIDTH=4, EXP_HEIGHT=3, CTL=1, then send one clean 4x3 frame → FRAME_COUNT=1, ERR_COUNT=0, STATUS=0b10.
- Same setup; line 1 has tlast at x=2 → ERR_COUNT=1, frame still counted, STATUS.bit1=0.
- tuser asserted at x=1, y=1, then a full clean frame → ERR_COUNT=1, FRAME_COUNT=1 (only the clean frame counted).
- ERR_COUNT=5, write reg6 in the same cycle as an error beat → ERR_COUNT reads 0.
- With CHECKSUM_EN, 2x2 frame with data 1, 2, 3, 4 → reg7 = 10; without the macro → reg7 = 0.
